// File: rtl/rr_reg_arbiter_if.sv
// Request/grant bundle between the requesters and the shared-register arbiter.
interface rr_reg_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [IW-1:0]  owner;
    logic           busy;

    // Requester side drives requests and data, observes the register and grant.
    modport master (
        output req, lock, wdata,
        input  gnt, q, owner, busy
    );

    // Arbiter side.
    modport slave (
        input  req, lock, wdata,
        output gnt, q, owner, busy
    );
endinterface

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter owning one shared W-bit register; a locked owner may
// keep it for at most MAX_HOLD consecutive cycles before it is rotated away.
module rr_reg_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    rr_reg_arbiter_if.slave bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HW = $clog2(MAX_HOLD) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [IW-1:0] owner_r, owner_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [N-1:0]  gnt_r, gnt_nxt;
    logic [W-1:0]  q_r, q_nxt;

    logic          cont;
    logic          found;
    logic [IW-1:0] writer;
    int unsigned   idx;

    // Pick this edge's writer: extend a locked owner, else rotate-scan from ptr.
    always_comb begin
        state_nxt = IDLE;
        ptr_nxt   = ptr;
        owner_nxt = owner_r;
        hold_nxt  = hold_cnt;
        gnt_nxt   = '0;
        q_nxt     = q_r;
        found     = 1'b0;
        writer    = '0;
        idx       = 0;

        cont = (state == GRANT) && bus.req[owner_r] && bus.lock[owner_r]
               && (hold_cnt < HW'(MAX_HOLD - 1));

        if (cont) begin
            found    = 1'b1;
            writer   = owner_r;
            hold_nxt = hold_cnt + HW'(1);
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!found && bus.req[IW'(idx)]) begin
                    found  = 1'b1;
                    writer = IW'(idx);
                end
            end
            if (found) begin
                ptr_nxt   = (writer == IW'(N - 1)) ? '0 : writer + IW'(1);
                hold_nxt  = '0;
                owner_nxt = writer;
            end
        end

        if (found) begin
            q_nxt     = bus.wdata[int'(writer)*W +: W];
            gnt_nxt   = N'(1) << writer;
            state_nxt = GRANT;
        end
    end

    // State and output registers; reset may arrive at any time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            owner_r  <= '0;
            hold_cnt <= '0;
            gnt_r    <= '0;
            q_r      <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner_r  <= owner_nxt;
            hold_cnt <= hold_nxt;
            gnt_r    <= gnt_nxt;
            q_r      <= q_nxt;
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.q     = q_r;
    assign bus.owner = owner_r;
    assign bus.busy  = (state == GRANT);
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Scoreboard bench for rr_reg_arbiter: a reference model pushes the expected
// outputs of each driven cycle, and they are popped after the clock edge.
module tb_rr_reg_arbiter;
    localparam int unsigned N        = 4;
    localparam int unsigned W        = 8;
    localparam int unsigned MAX_HOLD = 4;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [W-1:0] q;
        logic [1:0]   owner;
        logic         busy;
    } exp_t;

    logic clk;
    logic reset_n;

    rr_reg_arbiter_if #(.N(N), .W(W)) bus ();

    rr_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks;
    int   n_pass;
    exp_t sb[$];

    // reference model state
    int unsigned  m_ptr;
    int unsigned  m_hold;
    int unsigned  m_owner;
    logic         m_busy;
    logic [W-1:0] m_q;
    logic [N-1:0] m_gnt;

    logic [N*W-1:0] wd_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_hold  = 0;
        m_owner = 0;
        m_busy  = 1'b0;
        m_q     = '0;
        m_gnt   = '0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l,
                              input logic [N*W-1:0] wd);
        int  wr;
        bit  have;
        have = 0;
        wr   = 0;
        if (m_busy && r[m_owner] && l[m_owner] && (m_hold + 1 < MAX_HOLD)) begin
            have   = 1;
            wr     = int'(m_owner);
            m_hold = m_hold + 1;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                int c;
                c = (int'(m_ptr) + k) % int'(N);
                if (!have && r[c]) begin
                    have = 1;
                    wr   = c;
                end
            end
            if (have) begin
                m_ptr   = (wr + 1) % N;
                m_hold  = 0;
                m_owner = wr;
            end
        end
        if (have) begin
            m_q    = wd[wr*W +: W];
            m_gnt  = '0;
            m_gnt[wr] = 1'b1;
            m_busy = 1'b1;
        end else begin
            m_gnt  = '0;
            m_busy = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, predict, then compare after the edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                        input logic [N*W-1:0] wd);
        exp_t e;
        @(negedge clk);
        bus.req   = r;
        bus.lock  = l;
        bus.wdata = wd;
        model_step(r, l, wd);
        sb.push_back('{gnt: m_gnt, q: m_q, owner: 2'(m_owner), busy: m_busy});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("gnt",    32'(bus.gnt),   32'(e.gnt));
        check("q",      32'(bus.q),     32'(e.q));
        check("owner",  32'(bus.owner), 32'(e.owner));
        check("busy",   32'(bus.busy),  32'(e.busy));
        check("onehot", 32'($onehot0(bus.gnt)), 32'd1);
    endtask

    logic [N-1:0]   t1_gnt [5];
    logic [W-1:0]   t1_q   [5];
    logic [N-1:0]   t2_gnt [6];
    logic [N-1:0]   t3_gnt [4];
    logic [N*W-1:0] wd;

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        wd_base   = {8'h44, 8'h33, 8'h22, 8'h11};
        t1_gnt    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t1_q      = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        t2_gnt    = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
        t3_gnt    = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
        bus.req   = '0;
        bus.lock  = '0;
        bus.wdata = wd_base;
        reset_n   = 1'b0;
        model_reset();
        #12;
        check("rst_gnt",   32'(bus.gnt),   32'd0);
        check("rst_q",     32'(bus.q),     32'd0);
        check("rst_owner", 32'(bus.owner), 32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        reset_n = 1'b1;

        // plain round robin, all requesting
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 4'b0000, wd_base);
            check("rr_gnt", 32'(bus.gnt), 32'(t1_gnt[i]));
            check("rr_q",   32'(bus.q),   32'(t1_q[i]));
        end

        // move ownership to 3, then go idle: q and owner must hold
        step(4'b1000, 4'b0000, wd_base);
        for (int i = 0; i < 2; i++) begin
            step(4'b0000, 4'b0000, wd_base);
            check("idle_gnt",   32'(bus.gnt),   32'd0);
            check("idle_busy",  32'(bus.busy),  32'd0);
            check("idle_q",     32'(bus.q),     32'h44);
            check("idle_owner", 32'(bus.owner), 32'd3);
        end

        // lock held to MAX_HOLD, forced rotation, then back
        for (int i = 0; i < 6; i++) begin
            step(4'b0011, 4'b0001, wd_base);
            check("hold_gnt", 32'(bus.gnt), 32'(t2_gnt[i]));
        end

        // re-centre pointer on 0, then lock released early
        step(4'b1000, 4'b0000, wd_base);
        for (int i = 0; i < 4; i++) begin
            step(4'b0011, (i < 3) ? 4'b0001 : 4'b0000, wd_base);
            check("rel_gnt", 32'(bus.gnt), 32'(t3_gnt[i]));
        end

        // sole requester re-granted every cycle with fresh data
        for (int i = 0; i < 3; i++) begin
            wd = wd_base;
            wd[2*W +: W] = 8'hA0 + 8'(i);
            step(4'b0100, 4'b0000, wd);
            check("sole_gnt",   32'(bus.gnt),   32'b0100);
            check("sole_q",     32'(bus.q),     32'hA0 + 32'(i));
            check("sole_owner", 32'(bus.owner), 32'd2);
        end

        // sole locked requester across forced release keeps gnt high
        for (int i = 0; i < 6; i++) begin
            step(4'b0001, 4'b0001, wd_base);
            check("solelock_gnt", 32'(bus.gnt), 32'b0001);
        end

        // asynchronous reset in the middle of a lock burst
        step(4'b0011, 4'b0001, wd_base);
        step(4'b0011, 4'b0001, wd_base);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_gnt",  32'(bus.gnt),  32'd0);
        check("arst_q",    32'(bus.q),    32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        model_reset();
        reset_n = 1'b1;
        step(4'b1000, 4'b0000, wd_base);
        check("post_rst_gnt", 32'(bus.gnt), 32'b1000);
        check("post_rst_q",   32'(bus.q),   32'h44);

        // random traffic against the model
        for (int i = 0; i < 80; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), {$urandom, $urandom} >> 32);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
